// File: rtl/fluxo_dados_param.sv
// fluxo_dados_param: modulo-MODULO up/down counter with saturating parallel
// load, unsigned magnitude comparator against chaves, terminal-count flag
// and a saturating counter of rising edges of the equality flag.
//
// Configuration macro: COMPARADOR_REG_EN
//   undefined (default): menor/maior/igual are combinational.
//   defined            : menor/maior/igual are registered (1-cycle latency)
//                        and forced to 0 while reset is asserted.
module fluxo_dados_param #(
  parameter int N      = 4,
  parameter int MODULO = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         carrega,
  input  logic         conta,
  input  logic         desce,
  input  logic [N-1:0] chaves,
  output logic         menor,
  output logic         maior,
  output logic         igual,
  output logic         fim,
  output logic [N-1:0] db_contagem,
  output logic [N-1:0] db_acertos
);

  // Terminal value when counting up; also the ceiling for a saturating load.
  localparam logic [N-1:0] LAST        = N'(MODULO - 1);
  // MODULO may equal 2^N, so the load check is done one bit wider.
  localparam logic [N:0]   MOD_EXT     = (N + 1)'(MODULO);
  localparam logic [N-1:0] ACERTOS_MAX = {N{1'b1}};

  logic [N-1:0] contagem_q, contagem_d;
  logic [N-1:0] acertos_q, acertos_d;
  logic         igual_hist_q;
  logic [N-1:0] carga_sat;
  logic         lt_c, gt_c, eq_c;
  logic         match_edge;

  // Load value clipped to MODULO-1 so the counter never leaves its range.
  assign carga_sat = ({1'b0, chaves} >= MOD_EXT) ? LAST : chaves;

  // Next count: clear beats load beats count; otherwise hold.
  always_comb begin
    contagem_d = contagem_q;
    if (zera) begin
      contagem_d = '0;
    end else if (carrega) begin
      contagem_d = carga_sat;
    end else if (conta) begin
      if (desce) begin
        contagem_d = (contagem_q == '0) ? LAST : contagem_q - 1'b1;
      end else begin
        contagem_d = (contagem_q == LAST) ? '0 : contagem_q + 1'b1;
      end
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) contagem_q <= '0;
    else        contagem_q <= contagem_d;
  end

  // Unsigned magnitude compare of the live count against the switches.
  assign lt_c = (contagem_q <  chaves);
  assign gt_c = (contagem_q >  chaves);
  assign eq_c = (contagem_q == chaves);

`ifdef COMPARADOR_REG_EN
  logic menor_q, maior_q, igual_q;

  // Registered comparator outputs; all-zero while in reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      menor_q <= 1'b0;
      maior_q <= 1'b0;
      igual_q <= 1'b0;
    end else begin
      menor_q <= lt_c;
      maior_q <= gt_c;
      igual_q <= eq_c;
    end
  end

  assign menor = menor_q;
  assign maior = maior_q;
  assign igual = igual_q;
`else
  assign menor = lt_c;
  assign maior = gt_c;
  assign igual = eq_c;
`endif

  // Rising edge of the equality flag as it appears on the output pin, so the
  // match count follows whichever comparator timing is built.
  assign match_edge = igual & ~igual_hist_q;

  // Saturating match count; a clear in the same cycle as a match wins.
  always_comb begin
    acertos_d = acertos_q;
    if (zera) begin
      acertos_d = '0;
    end else if (match_edge && (acertos_q != ACERTOS_MAX)) begin
      acertos_d = acertos_q + 1'b1;
    end
  end

  // Match counter and the one-cycle history of the equality output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acertos_q    <= '0;
      igual_hist_q <= 1'b0;
    end else begin
      acertos_q    <= acertos_d;
      igual_hist_q <= igual;
    end
  end

  // Terminal flag depends only on direction and count, not on the enable.
  assign fim = desce ? (contagem_q == '0) : (contagem_q == LAST);

  assign db_contagem = contagem_q;
  assign db_acertos  = acertos_q;

endmodule

// File: tb/tb_fluxo_dados_param.sv
// Directed testbench for fluxo_dados_param (default build, combinational
// comparator). Instance u_a uses N=4, MODULO=10; instance u_b uses N=2,
// MODULO=4 for the match-count saturation case.
module tb_fluxo_dados_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A signals (N=4, MODULO=10)
  logic       a_reset, a_zera, a_carrega, a_conta, a_desce;
  logic [3:0] a_chaves;
  logic       a_menor, a_maior, a_igual, a_fim;
  logic [3:0] a_cont, a_acert;

  // Instance B signals (N=2, MODULO=4)
  logic       b_reset, b_zera, b_carrega, b_conta, b_desce;
  logic [1:0] b_chaves;
  logic       b_menor, b_maior, b_igual, b_fim;
  logic [1:0] b_cont, b_acert;

  int checks = 0;
  int errors = 0;

  fluxo_dados_param #(.N(4), .MODULO(10)) u_a (
    .clock(clock), .reset(a_reset), .zera(a_zera), .carrega(a_carrega),
    .conta(a_conta), .desce(a_desce), .chaves(a_chaves),
    .menor(a_menor), .maior(a_maior), .igual(a_igual), .fim(a_fim),
    .db_contagem(a_cont), .db_acertos(a_acert)
  );

  fluxo_dados_param #(.N(2), .MODULO(4)) u_b (
    .clock(clock), .reset(b_reset), .zera(b_zera), .carrega(b_carrega),
    .conta(b_conta), .desce(b_desce), .chaves(b_chaves),
    .menor(b_menor), .maior(b_maior), .igual(b_igual), .fim(b_fim),
    .db_contagem(b_cont), .db_acertos(b_acert)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int e;
    a_reset = 1'b0; a_zera = 1'b0; a_carrega = 1'b0; a_conta = 1'b0;
    a_desce = 1'b0; a_chaves = 4'd5;
    b_reset = 1'b0; b_zera = 1'b0; b_carrega = 1'b0; b_conta = 1'b0;
    b_desce = 1'b0; b_chaves = 2'd0;
    #2;
    $display("reset: cont=%0d acert=%0d fim=%0d menor=%0d", a_cont, a_acert, a_fim, a_menor);
    check("rst_cont",  a_cont,  0);
    check("rst_acert", a_acert, 0);
    check("rst_fim",   a_fim,   0);
    check("rst_menor", a_menor, 1);
    check("rst_igual", a_igual, 0);

    step();
    a_reset = 1'b1;
    a_conta = 1'b1;
    // Count up 20 edges with chaves=5: wraps 9->0 and matches twice.
    for (int i = 1; i <= 20; i++) begin
      step();
      e = i % 10;
      $display("up edge %0d: cont=%0d fim=%0d lt/eq/gt=%0d%0d%0d acert=%0d",
               i, a_cont, a_fim, a_menor, a_igual, a_maior, a_acert);
      check("up_cont",  a_cont,  e);
      check("up_fim",   a_fim,   (e == 9) ? 1 : 0);
      check("up_igual", a_igual, (e == 5) ? 1 : 0);
      check("up_menor", a_menor, (e < 5) ? 1 : 0);
      check("up_maior", a_maior, (e > 5) ? 1 : 0);
    end
    check("acert_two_laps", a_acert, 2);

    for (int i = 0; i < 7; i++) step();
    $display("mid-count: cont=%0d acert=%0d", a_cont, a_acert);
    check("mid_cont",  a_cont,  7);
    check("mid_acert", a_acert, 3);

    // Asynchronous reset between clock edges.
    a_conta = 1'b0;
    #2;
    a_reset = 1'b0;
    #1;
    $display("async reset: cont=%0d acert=%0d", a_cont, a_acert);
    check("async_cont",  a_cont,  0);
    check("async_acert", a_acert, 0);
    #1;
    a_reset = 1'b1;

    // Down from 0 wraps to 9.
    a_desce = 1'b1; a_conta = 1'b1;
    #1;
    check("down_fim_at0", a_fim, 1);
    step();
    $display("down: cont=%0d fim=%0d", a_cont, a_fim);
    check("down_wrap", a_cont, 9);
    check("down_fim9", a_fim,  0);
    a_desce = 1'b0; a_conta = 1'b0;
    #1;
    check("fim_no_conta", a_fim, 1);
    step();
    check("hold", a_cont, 9);

    // Loads: in-range, then saturating.
    a_chaves = 4'd2; a_carrega = 1'b1;
    step();
    $display("load 2: cont=%0d", a_cont);
    check("load2", a_cont, 2);
    a_chaves = 4'd13;
    step();
    $display("load 13: cont=%0d menor=%0d", a_cont, a_menor);
    check("load13_sat", a_cont,  9);
    check("cmp_9_13",   a_menor, 1);
    a_carrega = 1'b0; a_chaves = 4'd9;
    #1;
    check("cmp_9_9", a_igual, 1);
    a_chaves = 4'd3; a_carrega = 1'b1;
    step();
    check("load3", a_cont, 3);
    // Clear with load and count all asserted while a match edge is pending.
    a_zera = 1'b1; a_conta = 1'b1;
    step();
    $display("zera+carrega+conta: cont=%0d acert=%0d", a_cont, a_acert);
    check("zera_prio_cont",  a_cont,  0);
    check("zera_prio_acert", a_acert, 0);
    a_zera = 1'b0; a_carrega = 1'b0; a_conta = 1'b0;

    // Instance B: chaves=0, free-run; match count saturates at 3.
    b_reset = 1'b1;
    #1;
    check("b_rst_acert", b_acert, 0);
    check("b_igual0",    b_igual, 1);
    b_conta = 1'b1;
    step();
    $display("b edge 1: cont=%0d acert=%0d", b_cont, b_acert);
    check("b_first_match", b_acert, 1);
    for (int i = 0; i < 3; i++) step();
    check("b_lap_cont",  b_cont,  0);
    check("b_lap_acert", b_acert, 1);
    step();
    check("b_second_match", b_acert, 2);
    for (int i = 0; i < 75; i++) step();
    $display("b after 80 edges: cont=%0d acert=%0d", b_cont, b_acert);
    check("b_sat_acert", b_acert, 3);
    check("b_end_cont",  b_cont,  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
